// File: rtl/pdm_capture_sequencer.sv
// PDM microphone sequencer: clock/strobe generation, settle window, PCM FIFO.
// Define PDM_SEQ_OVERRUN_IRQ_EN to let the sticky overrun flag drive irq.
module pdm_capture_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_W   = 16,
  parameter int SETTLE_W   = 12,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_enable,
  input  logic [7:0]          cfg_clk_half,
  input  logic [7:0]          cfg_decim,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [LW-1:0]       cfg_thresh,
  output logic                pdm_clk,
  output logic                sample_strobe,
  output logic                filt_clear,
  output logic                filt_dump,
  input  logic [SAMPLE_W-1:0] filt_pcm,
  input  logic                filt_pcm_valid,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [LW-1:0]       fifo_level,
  output logic                overrun,
  input  logic                clr_overrun,
  output logic [1:0]          state,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } st_t;

  st_t                 r_state;
  st_t                 w_state_nxt;
  logic [7:0]          r_div;
  logic [7:0]          r_decim;
  logic                r_pdm;
  logic                r_strobe;
  logic                r_dump;
  logic [SETTLE_W-1:0] r_settle;
  logic [LW-1:0]       r_thresh;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;
  logic                r_overrun;

  logic                w_run;
  logic                w_act_nxt;
  logic                w_settled;
  logic [7:0]          w_div_nxt;
  logic [7:0]          w_decim_nxt;
  logic                w_pdm_nxt;
  logic                w_strobe_nxt;
  logic                w_dump_nxt;
  logic                w_push;
  logic                w_discard;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic                w_ovf;
  logic                w_lvl_irq;

  assign w_run     = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_settled = (r_settle >= cfg_settle);
  assign w_act_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (cfg_enable) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = cfg_enable ? S_SETTLE : S_IDLE;
      S_SETTLE: begin
        if (!cfg_enable)    w_state_nxt = S_IDLE;
        else if (w_settled) w_state_nxt = S_RUN;
      end
      S_RUN:    if (!cfg_enable) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe and dump are predicted one edge ahead so they leave on flops.
  always_comb begin
    w_div_nxt   = '0;
    w_pdm_nxt   = 1'b0;
    w_decim_nxt = '0;
    if (w_run && w_act_nxt) begin
      if (r_div >= cfg_clk_half) begin
        w_div_nxt = '0;
        w_pdm_nxt = ~r_pdm;
      end else begin
        w_div_nxt = r_div + 8'd1;
        w_pdm_nxt = r_pdm;
      end
      if (r_strobe)
        w_decim_nxt = r_dump ? 8'd0 : r_decim + 8'd1;
      else
        w_decim_nxt = r_decim;
    end
    w_strobe_nxt = w_pdm_nxt && (w_div_nxt >= cfg_clk_half);
    w_dump_nxt   = w_strobe_nxt && (w_decim_nxt == cfg_decim - 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_decim  <= '0;
      r_pdm    <= 1'b0;
      r_strobe <= 1'b0;
      r_dump   <= 1'b0;
      r_thresh <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_decim  <= w_decim_nxt;
      r_pdm    <= w_pdm_nxt;
      r_strobe <= w_strobe_nxt;
      r_dump   <= w_dump_nxt;
      r_thresh <= cfg_thresh;
    end
  end

  assign w_push = filt_pcm_valid &&
                  ((r_state == S_RUN) ||
                   ((r_state == S_SETTLE) && w_settled));
  assign w_discard = filt_pcm_valid &&
                     (r_state == S_SETTLE) && !w_settled;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_settle <= '0;
    else if (r_state == S_CLEAR)
      r_settle <= '0;
    else if (w_discard)
      r_settle <= r_settle + 1'b1;
  end

  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = rd_en && (r_level != '0);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst_n && w_wr && (r_state != S_CLEAR))
      r_mem[r_wptr] <= filt_pcm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
      // A fresh overrun wins over a same-cycle clear request.
      if (w_ovf)            r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign w_lvl_irq = (r_thresh != '0) && (r_level >= r_thresh);

`ifdef PDM_SEQ_OVERRUN_IRQ_EN
  assign irq = w_lvl_irq || r_overrun;
`else
  assign irq = w_lvl_irq;
`endif

  assign pdm_clk       = r_pdm;
  assign sample_strobe = r_strobe;
  assign filt_dump     = r_dump;
  assign filt_clear    = (r_state == S_CLEAR);
  assign state         = r_state;
  assign fifo_level    = r_level;
  assign overrun       = r_overrun;
  assign rd_data       = (r_level != '0) ? r_mem[r_rptr] : '0;

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// Directed bench for pdm_capture_sequencer: clocking, decimation, settle,
// FIFO overrun, threshold irq, disable and reset.
module tb_pdm_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [7:0]  cfg_clk_half;
  logic [7:0]  cfg_decim;
  logic [11:0] cfg_settle;
  logic [2:0]  cfg_thresh;
  logic        pdm_clk;
  logic        sample_strobe;
  logic        filt_clear;
  logic        filt_dump;
  logic [15:0] filt_pcm;
  logic        filt_pcm_valid;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [2:0]  fifo_level;
  logic        overrun;
  logic        clr_overrun;
  logic [1:0]  state;
  logic        irq;

  int total = 0;
  int bad   = 0;

  pdm_capture_sequencer #(
    .FIFO_DEPTH(4),
    .SAMPLE_W(16),
    .SETTLE_W(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_enable(cfg_enable),
    .cfg_clk_half(cfg_clk_half),
    .cfg_decim(cfg_decim),
    .cfg_settle(cfg_settle),
    .cfg_thresh(cfg_thresh),
    .pdm_clk(pdm_clk),
    .sample_strobe(sample_strobe),
    .filt_clear(filt_clear),
    .filt_dump(filt_dump),
    .filt_pcm(filt_pcm),
    .filt_pcm_valid(filt_pcm_valid),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .fifo_level(fifo_level),
    .overrun(overrun),
    .clr_overrun(clr_overrun),
    .state(state),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    filt_pcm = w;
    filt_pcm_valid = 1'b1;
    tick();
    filt_pcm_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  int sc;
  int dc;
  int di;
  int nds;
  logic exp_ovf_irq;

  initial begin
`ifdef PDM_SEQ_OVERRUN_IRQ_EN
    exp_ovf_irq = 1'b1;
`else
    exp_ovf_irq = 1'b0;
`endif
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    cfg_clk_half = 8'd0;
    cfg_decim = 8'd0;
    cfg_settle = 12'd0;
    cfg_thresh = 3'd0;
    filt_pcm = 16'h0;
    filt_pcm_valid = 1'b0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_state", state, 0);
    chk("rst_pdm", pdm_clk, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_clr", filt_clear, 0);

    // H=1, N=4, S=0
    cfg_clk_half = 8'd1;
    cfg_decim = 8'd4;
    cfg_enable = 1'b1;
    tick();
    chk("clear_state", state, 1);
    chk("clear_pulse", filt_clear, 1);
    tick();
    chk("clear_end", filt_clear, 0);
    for (int k = 0; k < 20; k++) begin
      chk("clk_state", state, (k == 0) ? 2 : 3);
      chk("clk_pdm", pdm_clk, (k >> 1) & 1);
      chk("clk_strobe", sample_strobe, (k % 4) == 3);
      chk("clk_dump", filt_dump, k == 15);
      tick();
    end
    cfg_enable = 1'b0;
    tick();
    chk("dis1_state", state, 0);
    chk("dis1_pdm", pdm_clk, 0);

    // N=0 -> dump every 256th strobe, H=0
    cfg_clk_half = 8'd0;
    cfg_decim = 8'd0;
    cfg_enable = 1'b1;
    tick();
    tick();
    sc = 0; dc = 0; di = 0; nds = 0;
    for (int k = 0; k < 600; k++) begin
      if (sample_strobe) sc++;
      if (filt_dump) begin
        dc++;
        di = sc;
        if (!sample_strobe) nds++;
      end
      tick();
    end
    chk("n0_strobes", sc, 300);
    chk("n0_dumps", dc, 1);
    chk("n0_dump_idx", di, 256);
    chk("n0_dump_nostb", nds, 0);
    cfg_enable = 1'b0;
    tick();

    // settle window S=3
    cfg_clk_half = 8'd7;
    cfg_decim = 8'd4;
    cfg_settle = 12'd3;
    cfg_enable = 1'b1;
    tick();
    tick();
    chk("set_state", state, 2);
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("set_level", fifo_level, 2);
    chk("set_head", rd_data, 16'h0004);
    chk("set_run", state, 3);
    pop();
    chk("set_pop_head", rd_data, 16'h0005);
    chk("set_pop_lvl", fifo_level, 1);
    cfg_enable = 1'b0;
    tick();
    chk("idle_keep", fifo_level, 1);

    // overrun, S=0
    cfg_settle = 12'd0;
    cfg_clk_half = 8'd1;
    cfg_enable = 1'b1;
    tick();
    tick();
    chk("flush_lvl", fifo_level, 0);
    for (int i = 0; i < 5; i++) push(16'hA1 + 16'(i));
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overrun, 1);
    chk("ovf_head", rd_data, 16'h00A1);
    chk("ovf_irq", irq, exp_ovf_irq);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovf_clr", overrun, 0);
    filt_pcm = 16'h00B0;
    filt_pcm_valid = 1'b1;
    rd_en = 1'b1;
    tick();
    filt_pcm_valid = 1'b0;
    rd_en = 1'b0;
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", overrun, 0);
    chk("pp_head", rd_data, 16'h00A2);
    pop();
    chk("drain_a3", rd_data, 16'h00A3);
    pop();
    chk("drain_a4", rd_data, 16'h00A4);
    pop();
    chk("drain_b0", rd_data, 16'h00B0);
    pop();
    chk("drain_lvl", fifo_level, 0);
    chk("drain_rd", rd_data, 0);

    // threshold irq
    cfg_thresh = 3'd2;
    tick();
    push(16'h00C1);
    chk("th1_lvl", fifo_level, 1);
    chk("th1_irq", irq, 0);
    push(16'h00C2);
    chk("th2_irq", irq, 1);
    pop();
    chk("th3_irq", irq, 0);
    chk("th3_head", rd_data, 16'h00C2);
    cfg_enable = 1'b0;
    tick();
    chk("dis2_state", state, 0);
    chk("dis2_pdm", pdm_clk, 0);
    chk("dis2_lvl", fifo_level, 1);
    chk("dis2_head", rd_data, 16'h00C2);
    pop();
    chk("idle_pop", fifo_level, 0);
    pop();
    chk("empty_pop", fifo_level, 0);
    chk("empty_rd", rd_data, 0);

    // reset mid-run
    cfg_enable = 1'b1;
    repeat (6) tick();
    push(16'h00D1);
    chk("pre_rst_lvl", fifo_level, 1);
    rst_n = 1'b0;
    tick();
    chk("mrst_state", state, 0);
    chk("mrst_lvl", fifo_level, 0);
    chk("mrst_pdm", pdm_clk, 0);
    chk("mrst_stb", sample_strobe, 0);
    rst_n = 1'b1;
    cfg_enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
